// File: rtl/tank_cmd_gen.sv
// Tank direction/fire command producer: synchronizes and debounces the player
// buttons, issues one direction strobe per game frame and a held fire request.
module tank_cmd_gen #(
  parameter int FRAME_DIV     = 833333,
  parameter int DEBOUNCE      = 250000,
  parameter int FIRE_COOLDOWN = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic [1:0] game_state,
  input  logic       fire_ack,
  output logic [2:0] direction_in,
  output logic       valid_take_direction,
  output logic       fire_req,
  output logic       frame_tick
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int FW = $clog2(FRAME_DIV);
  localparam int NB = 5;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_STAND = 3'd4;

  localparam logic [1:0] GS_PLAY = 2'b01;

  typedef enum logic [1:0] {
    FIRE_IDLE,
    FIRE_REQ,
    FIRE_COOL
  } fire_state_t;

  logic [NB-1:0] raw_btn;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [DW-1:0] db_cnt [NB];

  logic [FW-1:0] frame_cnt;
  logic          play;

  logic [2:0]    dir_enc;
  logic [2:0]    dir_q;
  logic          valid_q;

  fire_state_t   fire_state;
  fire_state_t   fire_state_next;
  logic [7:0]    cool_cnt;
  logic [7:0]    cool_cnt_next;
  logic          fire_prev;
  logic          fire_rise;

  assign raw_btn = {btn_fire, btn_right, btn_left, btn_down, btn_up};
  assign play    = (game_state == GS_PLAY);

  // Commit happens on the increment that would bring the count to DEBOUNCE,
  // so a change is stable exactly DEBOUNCE cycles after the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  always_comb begin
    dir_enc = DIR_STAND;
    if (stable[BTN_UP]) begin
      dir_enc = DIR_UP;
    end else if (stable[BTN_DOWN]) begin
      dir_enc = DIR_DOWN;
    end else if (stable[BTN_LEFT]) begin
      dir_enc = DIR_LEFT;
    end else if (stable[BTN_RIGHT]) begin
      dir_enc = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= DIR_STAND;
      valid_q <= 1'b0;
    end else if (!play) begin
      dir_q   <= DIR_STAND;
      valid_q <= 1'b0;
    end else if (frame_tick) begin
      dir_q   <= dir_enc;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Leaving PLAY must take effect in the same cycle, so the outputs are gated.
  assign direction_in         = play ? dir_q : DIR_STAND;
  assign valid_take_direction = valid_q & play;

  assign fire_rise = stable[BTN_FIRE] & ~fire_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_state <= FIRE_IDLE;
      cool_cnt   <= '0;
      fire_prev  <= 1'b0;
    end else begin
      fire_state <= fire_state_next;
      cool_cnt   <= cool_cnt_next;
      fire_prev  <= stable[BTN_FIRE];
    end
  end

  always_comb begin
    fire_state_next = fire_state;
    cool_cnt_next   = cool_cnt;
    fire_req        = (fire_state == FIRE_REQ);
    if (!play) begin
      fire_state_next = FIRE_IDLE;
      cool_cnt_next   = '0;
    end else begin
      case (fire_state)
        FIRE_IDLE: begin
          if (fire_rise) begin
            fire_state_next = FIRE_REQ;
          end
        end
        FIRE_REQ: begin
          if (fire_ack) begin
            fire_state_next = FIRE_COOL;
            cool_cnt_next   = 8'(FIRE_COOLDOWN);
          end
        end
        FIRE_COOL: begin
          if (cool_cnt == '0) begin
            fire_state_next = FIRE_IDLE;
          end else if (frame_tick) begin
            cool_cnt_next = cool_cnt - 8'd1;
          end
        end
        default: begin
          fire_state_next = FIRE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tank_cmd_gen.sv
// Bench for tank_cmd_gen: encoder vector table, hand-written multi-cycle
// sequences and randomized stimulus compared against a behavioural model.
module tb_tank_cmd_gen;

  localparam int FD = 8;
  localparam int DB = 4;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btns = '0;          // {fire, right, left, down, up}
  logic [1:0] game_state = 2'b01;
  logic       fire_ack = 1'b0;

  logic [2:0] direction_in;
  logic       valid_take_direction;
  logic       fire_req;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tank_cmd_gen #(
    .FRAME_DIV    (FD),
    .DEBOUNCE     (DB),
    .FIRE_COOLDOWN(FC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .btn_up              (btns[0]),
    .btn_down            (btns[1]),
    .btn_left            (btns[2]),
    .btn_right           (btns[3]),
    .btn_fire            (btns[4]),
    .game_state          (game_state),
    .fire_ack            (fire_ack),
    .direction_in        (direction_in),
    .valid_take_direction(valid_take_direction),
    .fire_req            (fire_req),
    .frame_tick          (frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button history, run lengths, frame phase, fire flags.
  logic [4:0] m_q[$] = '{5'd0, 5'd0};
  logic [4:0] m_stable = '0;
  int         m_run[5] = '{0, 0, 0, 0, 0};
  int         m_phase = 0;
  logic [2:0] m_dir = 3'd4;
  logic       m_valid = 1'b0;
  logic       m_prev = 1'b0;
  logic       m_req = 1'b0;
  logic       m_cooling = 1'b0;
  int         m_left = 0;

  function automatic logic [2:0] prio_dir(input logic [4:0] st);
    for (int i = 0; i < 4; i++) begin
      if (st[i]) return 3'(i);
    end
    return 3'd4;
  endfunction

  task automatic model_reset();
    m_q = '{5'd0, 5'd0};
    m_stable = '0;
    for (int b = 0; b < 5; b++) m_run[b] = 0;
    m_phase = 0;
    m_dir = 3'd4;
    m_valid = 1'b0;
    m_prev = 1'b0;
    m_req = 1'b0;
    m_cooling = 1'b0;
    m_left = 0;
  endtask

  task automatic model_step();
    logic [4:0] seen;
    logic [4:0] old_st;
    logic       tick_now;
    logic       play;
    logic       rise;
    seen = m_q.pop_front();
    m_q.push_back(btns);
    old_st   = m_stable;
    tick_now = (m_phase == FD - 1);
    play     = (game_state == 2'b01);
    rise     = old_st[4] && !m_prev;
    for (int b = 0; b < 5; b++) begin
      if (seen[b] != old_st[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_stable[b] = seen[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_prev  = old_st[4];
    m_phase = (m_phase + 1) % FD;
    if (!play) begin
      m_dir = 3'd4;
      m_valid = 1'b0;
    end else if (tick_now) begin
      m_dir = prio_dir(old_st);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (!play) begin
      m_req = 1'b0;
      m_cooling = 1'b0;
      m_left = 0;
    end else if (m_req) begin
      if (fire_ack) begin
        m_req = 1'b0;
        m_cooling = 1'b1;
        m_left = FC;
      end
    end else if (m_cooling) begin
      if (m_left == 0) m_cooling = 1'b0;
      else if (tick_now) m_left--;
    end else if (rise) begin
      m_req = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    check("model_dir", direction_in, (game_state == 2'b01) ? m_dir : 3'd4);
    check("model_valid", valid_take_direction, m_valid && (game_state == 2'b01));
    check("model_fire_req", fire_req, m_req);
    check("model_tick", frame_tick, m_phase == FD - 1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for the next strobe; exp_gap > 0 also checks its arrival index.
  task automatic expect_strobe(input string name, input logic [2:0] exp_dir, input int exp_gap);
    int n = 0;
    logic got = 1'b0;
    logic [2:0] d = '0;
    while (!got && n < 4 * FD) begin
      @(negedge clk);
      n++;
      if (valid_take_direction) begin
        got = 1'b1;
        d = direction_in;
      end
    end
    check({name, "_seen"}, got, 1);
    if (got) check({name, "_dir"}, d, exp_dir);
    if (got && exp_gap > 0) check({name, "_gap"}, n, exp_gap);
  endtask

  task automatic wait_fire_req(input string name, output int n);
    n = 0;
    while (fire_req !== 1'b1 && n < 4 * FD) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, fire_req, 1);
  endtask

  typedef struct {
    logic [3:0] b;   // {right, left, down, up}
    logic [2:0] d;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    tbl[0]  = '{4'b0000, 3'd4};
    tbl[1]  = '{4'b0001, 3'd0};
    tbl[2]  = '{4'b0010, 3'd1};
    tbl[3]  = '{4'b0100, 3'd2};
    tbl[4]  = '{4'b1000, 3'd3};
    tbl[5]  = '{4'b0011, 3'd0};
    tbl[6]  = '{4'b0110, 3'd1};
    tbl[7]  = '{4'b1100, 3'd2};
    tbl[8]  = '{4'b1010, 3'd1};
    tbl[9]  = '{4'b1111, 3'd0};
    tbl[10] = '{4'b1001, 3'd0};

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dir", direction_in, 4);
    check("rst_valid", valid_take_direction, 0);
    check("rst_fire_req", fire_req, 0);
    check("rst_tick", frame_tick, 0);

    // Idle PLAY: first strobe on the 8th edge after release (negedge index 9).
    @(posedge clk);
    #2 rst = 1'b0;
    expect_strobe("idle_first", 3'd4, FD + 1);
    for (int i = 0; i < 3; i++) expect_strobe("idle", 3'd4, FD);
    check("idle_fire_req", fire_req, 0);

    // Short right glitch, then left held.
    cycles(1);
    btns[3] = 1'b1;
    cycles(3);
    btns[3] = 1'b0;
    cycles(4);
    btns[2] = 1'b1;
    cycles(10);
    expect_strobe("left_a", 3'd2, 0);
    expect_strobe("left_b", 3'd2, FD);
    expect_strobe("left_c", 3'd2, FD);

    // Up+right gives up; releasing up gives right.
    btns = 5'b01001;
    cycles(10);
    expect_strobe("upright", 3'd0, 0);
    expect_strobe("upright_b", 3'd0, FD);
    btns[0] = 1'b0;
    cycles(10);
    expect_strobe("right_only", 3'd3, 0);

    for (int i = 0; i < 11; i++) begin
      btns[3:0] = tbl[i].b;
      cycles(8);
      expect_strobe($sformatf("vec%0d", i), tbl[i].d, 0);
    end
    btns = '0;
    cycles(10);

    // Fire: request after sync + debounce + 1 edge, held until ack.
    btns[4] = 1'b1;
    wait_fire_req("fire1", n);
    check("fire1_latency", n, DB + 4);
    @(posedge clk);
    #2 btns[4] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("fire1_hold", fire_req, 1);
    end
    @(posedge clk);
    #2 fire_ack = 1'b1;
    @(negedge clk);
    check("fire1_hold_ack", fire_req, 1);
    @(posedge clk);
    #2 fire_ack = 1'b0;
    btns[4] = 1'b1;
    @(negedge clk);
    check("fire1_drop", fire_req, 0);
    cnt_a = 0;
    repeat (24) begin
      @(negedge clk);
      if (fire_req) cnt_a++;
    end
    check("fire_cooldown_drop", cnt_a, 0);
    btns[4] = 1'b0;
    cycles(10);
    btns[4] = 1'b1;
    wait_fire_req("fire2", n);
    check("fire2_latency", n, DB + 4);

    // Leaving PLAY with a pending request.
    @(posedge clk);
    #2 game_state = 2'b10;
    @(negedge clk);
    check("init_dir", direction_in, 4);
    check("init_valid", valid_take_direction, 0);
    @(negedge clk);
    check("init_fire_cleared", fire_req, 0);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) btns[4] = 1'b0;
      if (i == 10) btns[4] = 1'b1;
      @(negedge clk);
      if (frame_tick) cnt_a++;
      if (valid_take_direction) cnt_b++;
      if (fire_req) cnt_c++;
    end
    check("init_ticks", cnt_a, 3);
    check("init_strobes", cnt_b, 0);
    check("init_fire", cnt_c, 0);
    @(posedge clk);
    #2 game_state = 2'b01;
    cnt_c = 0;
    repeat (6) begin
      @(negedge clk);
      if (fire_req) cnt_c++;
    end
    check("reentry_fire", cnt_c, 0);
    expect_strobe("reentry", 3'd4, 0);
    btns[4] = 1'b0;
    cycles(10);

    // Reset while in REQ with down held.
    btns[1] = 1'b1;
    cycles(10);
    expect_strobe("down", 3'd1, 0);
    btns[4] = 1'b1;
    wait_fire_req("fire3", n);
    @(posedge clk);
    #2 rst = 1'b1;
    btns[4] = 1'b0;
    #1;
    check("arst_dir", direction_in, 4);
    check("arst_valid", valid_take_direction, 0);
    check("arst_fire_req", fire_req, 0);
    check("arst_tick", frame_tick, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    expect_strobe("post_rst", 3'd1, FD + 1);
    btns = '0;
    cycles(10);

    // Randomized stimulus; the model comparisons run every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 11) == 0) btns[b] = ~btns[b];
      end
      fire_ack = ($urandom_range(0, 5) == 0);
      if (game_state != 2'b01 && $urandom_range(0, 9) == 0) game_state = 2'b01;
      else if ($urandom_range(0, 49) == 0) game_state = 2'($urandom_range(0, 3));
    end
    fire_ack = 1'b0;
    game_state = 2'b01;
    btns = '0;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
